// File: rtl/clock_comp_pkg.sv
// Shared definitions for the TX clock-compensation datapath: FSM encoding,
// alignment-marker period calculation and counter-width helpers.
package clock_comp_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_READY   = 2'd1;
  localparam logic [1:0] ST_INSERT  = 2'd2;

  function automatic int unsigned calc_period(input int unsigned am_block_period,
                                              input int unsigned n_lanes);
    return am_block_period * n_lanes;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

  function automatic int unsigned pend_width(input int unsigned n_lanes);
    return (n_lanes < 1) ? 1 : $clog2(n_lanes + 1);
  endfunction

endpackage

// File: rtl/idle_del_scheduler.sv
// Schedules N_LANES idle deletions per alignment-marker period and tags the
// N_LANES AM slots at the end of the period; flags a sticky underrun.
module idle_del_scheduler
  import clock_comp_pkg::*;
#(
  parameter int unsigned N_LANES         = 20,
  parameter int unsigned AM_BLOCK_PERIOD = 60
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic                            i_valid,
  input  logic                            i_idle,
  output logic                            o_delete,
  output logic                            o_aligner_tag,
  output logic                            o_period_start,
  output logic                            o_underrun,
  output logic [pend_width(N_LANES)-1:0]  o_pending
);

  localparam int unsigned P  = calc_period(AM_BLOCK_PERIOD, N_LANES);
  localparam int unsigned CW = cnt_width(P);
  localparam int unsigned PW = pend_width(N_LANES);

  localparam logic [CW-1:0] CNT_LAST  = CW'(P - 1);
  localparam logic [CW-1:0] WIN_START = CW'(P - N_LANES);
  localparam logic [PW-1:0] PEND_INIT = PW'(N_LANES);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pend, pend_n;
  logic          del_n, tag_n, ps_n, und_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    del_n   = 1'b0;
    tag_n   = 1'b0;
    ps_n    = 1'b0;
    und_n   = o_underrun;
    if (i_enable && i_valid) begin
      cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      ps_n  = (cnt == '0);
      case (state)
        ST_COLLECT: begin
          // Reaching the window while still collecting means deletions are owed.
          if (cnt == WIN_START) begin
            tag_n   = 1'b1;
            und_n   = 1'b1;
            state_n = ST_INSERT;
          end else if (i_idle && (pend != '0)) begin
            del_n  = 1'b1;
            pend_n = pend - PEND_ONE;
            if (pend == PEND_ONE) state_n = ST_READY;
          end
        end
        ST_READY: begin
          if (cnt == WIN_START) begin
            tag_n   = 1'b1;
            state_n = ST_INSERT;
          end
        end
        ST_INSERT: tag_n = 1'b1;
        default:   state_n = ST_COLLECT;
      endcase
      // Wrap overrides the FSM: any undelivered deletions are discarded.
      if (cnt == CNT_LAST) begin
        state_n = ST_COLLECT;
        pend_n  = PEND_INIT;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_COLLECT;
      cnt            <= '0;
      pend           <= PEND_INIT;
      o_delete       <= 1'b0;
      o_aligner_tag  <= 1'b0;
      o_period_start <= 1'b0;
      o_underrun     <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      pend           <= pend_n;
      o_delete       <= del_n;
      o_aligner_tag  <= tag_n;
      o_period_start <= ps_n;
      o_underrun     <= und_n;
    end
  end

  assign o_pending = pend;

endmodule

// File: tb/tb_idle_del_scheduler.sv
// Scoreboard bench for idle_del_scheduler at default parameters (P = 1200).
module tb_idle_del_scheduler;

  localparam int N  = 20;
  localparam int P  = 1200;
  localparam int PW = 5;

  logic          tb_i_clock = 1'b0;
  logic          i_reset    = 1'b1;
  logic          i_enable   = 1'b0;
  logic          i_valid    = 1'b0;
  logic          i_idle     = 1'b0;
  logic          o_delete, o_aligner_tag, o_period_start, o_underrun;
  logic [PW-1:0] o_pending;

  idle_del_scheduler #(.N_LANES(20), .AM_BLOCK_PERIOD(60)) dut (
    .i_clock        (tb_i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_valid        (i_valid),
    .i_idle         (i_idle),
    .o_delete       (o_delete),
    .o_aligner_tag  (o_aligner_tag),
    .o_period_start (o_period_start),
    .o_underrun     (o_underrun),
    .o_pending      (o_pending)
  );

  always #5 tb_i_clock = ~tb_i_clock;

  typedef struct {
    logic d, t, ps, u;
    int   pend;
    int   blk;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state
  int   m_cnt, m_pend, m_blk;
  logic m_und;

  // per-scenario statistics from DUT outputs (blocks of the first period)
  int n_del, first_del, last_del, n_del_all;
  int n_tag, first_tag, last_tag;
  int n_ps, last_ps;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_del = 0; first_del = -1; last_del = -1; n_del_all = 0;
    n_tag = 0; first_tag = -1; last_tag = -1;
    n_ps  = 0; last_ps   = -1;
  endtask

  task automatic do_reset();
    @(negedge tb_i_clock);
    i_reset = 1'b1; i_valid = 1'b0; i_idle = 1'b0; i_enable = 1'b1;
    #1;
    check("rst_delete",  int'(o_delete),       0);
    check("rst_tag",     int'(o_aligner_tag),  0);
    check("rst_pstart",  int'(o_period_start), 0);
    check("rst_underrun",int'(o_underrun),     0);
    check("rst_pending", int'(o_pending),      N);
    m_cnt = 0; m_pend = N; m_und = 1'b0; m_blk = 0;
    q.delete();
    clear_stats();
    @(posedge tb_i_clock);
    #1;
    @(negedge tb_i_clock);
    i_reset = 1'b0;
  endtask

  task automatic step(input logic en, input logic v, input logic idl);
    exp_t e;
    @(negedge tb_i_clock);
    i_enable = en; i_valid = v; i_idle = idl;
    e.d = 1'b0; e.t = 1'b0; e.ps = 1'b0; e.blk = -1;
    if (en && v) begin
      e.blk = m_blk;
      m_blk++;
      e.ps = (m_cnt == 0);
      e.t  = (m_cnt >= P - N);
      e.d  = (m_cnt < P - N) && idl && (m_pend > 0);
      if (m_cnt == P - N && m_pend > 0) m_und = 1'b1;
      if (e.d) m_pend--;
      if (m_cnt == P - 1) begin
        m_cnt  = 0;
        m_pend = N;
      end else begin
        m_cnt++;
      end
    end
    e.u    = m_und;
    e.pend = m_pend;
    q.push_back(e);
    @(posedge tb_i_clock);
    #1;
    e = q.pop_front();
    check("delete",   int'(o_delete),       int'(e.d));
    check("tag",      int'(o_aligner_tag),  int'(e.t));
    check("pstart",   int'(o_period_start), int'(e.ps));
    check("underrun", int'(o_underrun),     int'(e.u));
    check("pending",  int'(o_pending),      e.pend);
    if (o_delete) begin
      n_del_all++;
      if (e.blk < P) begin
        n_del++;
        if (first_del < 0) first_del = e.blk;
        last_del = e.blk;
      end
    end
    if (o_aligner_tag && e.blk < P) begin
      n_tag++;
      if (first_tag < 0) first_tag = e.blk;
      last_tag = e.blk;
    end
    if (o_period_start) begin
      n_ps++;
      last_ps = e.blk;
    end
  endtask

  initial begin
    // 1: continuous valid idles
    do_reset();
    for (int b = 0; b < P + 20; b++) step(1'b1, 1'b1, 1'b1);
    check("s1_ndel",     n_del,     20);
    check("s1_firstdel", first_del, 0);
    check("s1_lastdel",  last_del,  19);
    check("s1_ndel_all", n_del_all, 40);
    check("s1_ntag",     n_tag,     20);
    check("s1_firsttag", first_tag, 1180);
    check("s1_lasttag",  last_tag,  1199);
    check("s1_nps",      n_ps,      2);
    check("s1_lastps",   last_ps,   1200);
    check("s1_underrun", int'(o_underrun), 0);

    // 2: data first, idles from block 1000
    do_reset();
    for (int b = 0; b < P; b++) step(1'b1, 1'b1, b >= 1000);
    check("s2_ndel",     n_del,     20);
    check("s2_firstdel", first_del, 1000);
    check("s2_lastdel",  last_del,  1019);
    check("s2_firsttag", first_tag, 1180);
    check("s2_ntag",     n_tag,     20);

    // 3: only five idles before the window -> underrun
    do_reset();
    for (int b = 0; b < P + 30; b++) step(1'b1, 1'b1, (b < 5) || (b >= 1180));
    check("s3_ndel",     n_del,     5);
    check("s3_ndel_all", n_del_all, 25);
    check("s3_ntag",     n_tag,     20);
    check("s3_firsttag", first_tag, 1180);
    check("s3_underrun", int'(o_underrun), 1);
    check("s3_pending",  int'(o_pending),  0);

    // 4: valid on every other cycle
    do_reset();
    for (int i = 0; i < 2 * (P + 10); i++) step(1'b1, (i % 2) == 0, 1'b1);
    check("s4_ndel",     n_del,     20);
    check("s4_lastdel",  last_del,  19);
    check("s4_firsttag", first_tag, 1180);
    check("s4_lasttag",  last_tag,  1199);
    check("s4_nps",      n_ps,      2);

    // 5: enable low for 10 cycles mid delete run
    do_reset();
    for (int b = 0; b < 10; b++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    check("s5_frozen_pend", int'(o_pending), 10);
    for (int b = 0; b < 20; b++) step(1'b1, 1'b1, 1'b1);
    check("s5_ndel",    n_del,    20);
    check("s5_lastdel", last_del, 19);

    // 6: reset pulsed at block 1190, mid-window
    do_reset();
    for (int b = 0; b <= 1190; b++) step(1'b1, 1'b1, 1'b1);
    check("s6_tag_before", int'(o_aligner_tag), 1);
    do_reset();
    for (int b = 0; b < 5; b++) step(1'b1, 1'b1, 1'b1);
    check("s6_firstdel", first_del, 0);
    check("s6_ndel",     n_del,     5);
    check("s6_nps",      n_ps,      1);
    check("s6_pending",  int'(o_pending), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
